md_sequencer: RTL
=================

Name: md_sequencer

Overview:
- Multi-cycle multiply/divide sequencer in the Execute stage, beside the ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E and holds the HI/LO registers.
- Runs a busy countdown that models the multiply and divide latency.
- Raises a stall toward Decode so that no HI/LO-using instruction issues while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >=1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >=1)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- Start_E  input  1  valid MD instruction in E this cycle
- MDOp_E  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved
- SrcA_E  input  32  rs operand (forwarded)
- SrcB_E  input  32  rt operand (forwarded)
- MDUse_D  input  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo
- Busy_E  output  1  operation in flight
- Stall_MD  output  1  stall request for F/D, flush for D->E
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- One clock domain; clk and reset are fixed as above.
- Reset (synchronous, active-high): HI=0, LO=0, Busy_E=0, counter=0, pending regs=0.
  - Reset mid-operation aborts the operation; HI/LO keep the reset value.
- States: IDLE (counter==0), RUN (counter>0). Busy_E = (counter!=0).
- IDLE + Start_E with MULT/MULTU/DIV/DIVU, sampled at edge t:
  - Full result computed combinationally from SrcA_E/SrcB_E into pending {P_HI,P_LO}.
  - counter <= MULT_CYCLES or DIV_CYCLES.
- RUN: counter decrements each edge.
  - At the edge where counter==1: HI<=P_HI, LO<=P_LO, counter<=0.
  - Busy_E is high exactly N cycles, t+1..t+N.
  - New HI/LO are visible from cycle t+N+1.
- MULT: signed 32x32->64; MULTU: unsigned. HI=product[63:32], LO=product[31:0].
- DIV: signed, truncation toward zero. LO=quotient; HI=remainder, sign follows the dividend.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0.
- DIVU: unsigned.
- Divide by zero (SrcB_E==0, DIV or DIVU): busy countdown still runs; HI/LO are unchanged at commit (pending loaded from current HI/LO).
- MTHI/MTLO in IDLE: HI or LO <= SrcA_E at the same edge; no busy.
- Reserved MDOp: ignored.
- Start_E while Busy_E=1: ignored, state and pending untouched. The stall prevents this case.
- Stall_MD = MDUse_D & (Start_E | Busy_E), purely combinational.
  - Covers both the issue cycle and the whole busy window.
- HI/LO outputs are registered. mfhi/mflo read them directly in E with no bypass; the stall guarantees they are final.

Decomposition:
- Shared constants header holds:
  - MDOp encodings (MD_MULT..MD_MTLO).
  - Default MULT_CYCLES/DIV_CYCLES.
  - The MDUse decode list used by the controller.
- One natural sub-module: md_core, combinational.
  - Inputs: op, a, b, current HI/LO.
  - Outputs: {P_HI,P_LO}, including the divide-by-zero hold.
- md_sequencer owns the counter, the HI/LO registers and the stall logic.

Test Plan:
- MULT 0xFFFFFFFF * 0x00000002 at cycle t:
  - Busy_E high t+1..t+5.
  - At t+6: HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU with the same operands: HI=0x00000001, LO=0xFFFFFFFE.
- DIV -7 (0xFFFFFFF9) / 2:
  - Busy_E for 10 cycles.
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/2: LO=3, HI=1.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles:
  - HI and LO update one edge later each.
  - Busy_E stays 0, Stall_MD stays 0.
- DIV x/0 with HI=0xAAAA0000, LO=0x5555FFFF:
  - Busy for 10 cycles.
  - HI/LO unchanged afterward.
- MDUse_D=1 during the MULT issue cycle and the busy window:
  - Stall_MD=1 for 6 cycles, 0 at t+6.
  - A second Start_E injected while busy is ignored.
- Reset asserted at t+3 of a MULT:
  - Next cycle Busy_E=0, HI=LO=0.
  - No commit at t+6.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// rtl/md_sequencer_pkg.sv - shared MD opcodes, latency defaults and decode helpers
package md_sequencer_pkg;

  // MDOp_E encodings; 6 and 7 are reserved and ignored
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // Default latencies of the multiply and divide units
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_pair_t;

  // Operations that occupy the unit and run the busy countdown
  function automatic logic md_is_long_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Every opcode the controller treats as an MD instruction
  function automatic logic md_is_md_op(input logic [2:0] op);
    return md_is_long_op(op) || (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

endpackage

// File: rtl/md_core.sv
// rtl/md_core.sv - combinational multiply/divide datapath producing the pending HI/LO pair
module md_core
  import md_sequencer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output md_pair_t    result
);

  logic        is_signed_mul;
  logic        is_signed_div;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Signed divide works on magnitudes through one shared unsigned divider, then restores signs
  always_comb begin
    is_signed_mul = (op == MD_MULT);
    is_signed_div = (op == MD_DIV);
    mul_a   = is_signed_mul ? {{32{a[31]}}, a} : {32'b0, a};
    mul_b   = is_signed_mul ? {{32{b[31]}}, b} : {32'b0, b};
    product = mul_a * mul_b;
    dividend = (is_signed_div && a[31]) ? (32'd0 - a) : a;
    divisor  = (is_signed_div && b[31]) ? (32'd0 - b) : b;
    if (divisor == 32'd0) begin
      divisor = 32'd1;
    end
    q_mag = dividend / divisor;
    r_mag = dividend % divisor;
    quot  = (is_signed_div && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
    rem   = (is_signed_div && a[31]) ? (32'd0 - r_mag) : r_mag;
    result.hi = cur_hi;
    result.lo = cur_lo;
    if ((op == MD_MULT) || (op == MD_MULTU)) begin
      result.hi = product[63:32];
      result.lo = product[31:0];
    end else if (md_is_div_op(op) && (b != 32'd0)) begin
      result.hi = rem;
      result.lo = quot;
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - HI/LO owner with busy countdown and decode stall for multi-cycle MD ops
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start_E,
  input  logic [2:0]  MDOp_E,
  input  logic [31:0] SrcA_E,
  input  logic [31:0] SrcB_E,
  input  logic        MDUse_D,
  output logic        Busy_E,
  output logic        Stall_MD,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [CW-1:0] counter;
  logic [31:0]   p_hi;
  logic [31:0]   p_lo;
  md_pair_t      core_res;

  md_core u_core (
    .op     (MDOp_E),
    .a      (SrcA_E),
    .b      (SrcB_E),
    .cur_hi (HI),
    .cur_lo (LO),
    .result (core_res)
  );

  assign Busy_E   = (counter != '0);
  assign Stall_MD = MDUse_D & (Start_E | Busy_E);

  // Launch, count down and commit; new starts are only accepted while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      HI      <= '0;
      LO      <= '0;
    end else if (Busy_E) begin
      if (counter == CW'(1)) begin
        HI      <= p_hi;
        LO      <= p_lo;
        counter <= '0;
      end else begin
        counter <= counter - CW'(1);
      end
    end else if (Start_E) begin
      if (md_is_long_op(MDOp_E)) begin
        p_hi    <= core_res.hi;
        p_lo    <= core_res.lo;
        counter <= md_is_div_op(MDOp_E) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (MDOp_E == MD_MTHI) begin
        HI <= SrcA_E;
      end else if (MDOp_E == MD_MTLO) begin
        LO <= SrcA_E;
      end
    end
  end

endmodule
